instr_fetch_unit: RTL

- Instruction producer for control_unit and the decode stage of the serialized core.
- Fetches 32-bit words from instruction memory over a valid/ready request channel and a response channel, and buffers them in a small prefetch FIFO.
- Issues one instruction at a time for CYCLES_PER_INST cycles. Drives opcode/funct3/funct7 plus the one-cycle first_cycle strobe that the decoder latches on.
- Flushes buffered and in-flight fetches on jump/branch redirect.

---
 rtl/instr_fetch_unit.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Instruction producer for the serialized core. Fetches 32-bit words over a
//   valid/ready request channel and an in-order response channel. Buffers the
//   words with their addresses in a small prefetch FIFO. Issues one
//   instruction at a time, holding it for CYCLES_PER_INST non-stalled cycles.
//   A redirect (taken jump/branch) flushes buffered words and discards every
//   response that is still in flight.
//
// Optional feature (compile-time macro IFU_ALIGN_CHECK_EN):
//   Defined   : a redirect whose target has nonzero low bits sets a sticky
//               fetch_fault_o (cleared only by reset). Fetching then halts
//               and no further instruction is issued after the current one.
//   Undefined : the low target bits are silently masked and fetch_fault_o
//               is constant 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req_*          fetch request (valid/ready handshake, word address)
//   imem_rsp_*          fetch response (in-order, always accepted)
//   redirect_i/_pc_i    one-cycle redirect pulse and its target address
//   stall_i             freezes the issue side
//   inst_valid_o        an instruction is being issued
//   first_cycle_o       high in issue cycle 0 of each instruction only
//   inst_o, pc_o        issued word and its address (held after completion)
//   opcode_o/funct3_o/funct7_o  decoded fields of inst_o
//   fetch_fault_o       misaligned redirect (feature build only)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          DEPTH           = 2,
    parameter int          CYCLES_PER_INST = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        inst_valid_o,
    output logic        first_cycle_o,
    output logic [31:0] inst_o,
    output logic [6:0]  opcode_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o,
    output logic [31:0] pc_o,
    output logic        fetch_fault_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = (CYCLES_PER_INST > 1) ? $clog2(CYCLES_PER_INST) : 1;

    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [NW-1:0] LAST_CNT  = NW'(CYCLES_PER_INST - 1);
    localparam logic [CW+1:0] DEPTH_SUM = (CW + 2)'(DEPTH);
    localparam logic [31:0]   NOP_INST  = 32'h0000_0013;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    // Fetch side state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;      // address of the next live response
    logic          req_valid_q, req_valid_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic          fault_q, fault_d;

    // Prefetch FIFO
    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Issue side state
    state_t        state_q, state_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [31:0]   inst_q, inst_d;
    logic [31:0]   pc_q, pc_d;
    logic          first_q, first_d;

    logic          hs;
    logic          rsp_live;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic          can_pop;
    logic [CW-1:0] out_after;
    logic [CW-1:0] disc_after;
    logic [CW+1:0] credit_used;
    logic [31:0]   redirect_target;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign hs              = req_valid_q & imem_req_ready_i;
    // While discard is nonzero the arriving word belongs to a flushed fetch.
    assign rsp_drop        = imem_rsp_valid_i && (discard_q != '0);
    assign rsp_live        = imem_rsp_valid_i && (discard_q == '0);
    // A live word arriving in the redirect cycle is still stale: drop it.
    assign push            = rsp_live && !redirect_i;
    assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
    assign can_pop         = (count_q != '0) && !stall_i && !redirect_i && !fault_q;

    // ---------------------------------------------------------------- fetch
    always_comb begin
        out_after     = outstanding_q + CW'(hs) - CW'(rsp_live);
        disc_after    = discard_q - CW'(rsp_drop);
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q + CW'(push) - CW'(pop);
        outstanding_d = out_after;
        discard_d     = disc_after;

        if (hs) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        if (redirect_i) begin
            // Everything still in flight (including a request accepted in
            // this very cycle) becomes discard credit.
            fetch_pc_d    = redirect_target;
            rsp_pc_d      = redirect_target;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            outstanding_d = '0;
            discard_d     = disc_after + out_after;
        end

`ifdef IFU_ALIGN_CHECK_EN
        fault_d = fault_q | (redirect_i && (redirect_pc_i[1:0] != 2'b00));
`else
        fault_d = 1'b0;
`endif

        // Credit: in-flight + buffered + to-be-dropped words never exceed
        // DEPTH, so the FIFO can never overflow.
        credit_used = {2'b00, outstanding_d} + {2'b00, count_d} + {2'b00, discard_d};
        req_valid_d = (credit_used < DEPTH_SUM) && !fault_d;
    end

    // ---------------------------------------------------------------- issue
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        first_d = 1'b0;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (can_pop) begin
                    pop = 1'b1;
                end
            end
            ISSUE: begin
                if (!stall_i) begin
                    if (cnt_q == LAST_CNT) begin
                        if (can_pop) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + NW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            state_d = ISSUE;
            cnt_d   = '0;
            inst_d  = fifo_inst[rd_ptr_q];
            pc_d    = fifo_pc[rd_ptr_q];
            first_d = 1'b1;
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            req_valid_q   <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            fault_q       <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            inst_q        <= NOP_INST;
            pc_q          <= RESET_PC;
            first_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            req_valid_q   <= req_valid_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fault_q       <= fault_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            inst_q        <= inst_d;
            pc_q          <= pc_d;
            first_q       <= first_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr_q] <= imem_rsp_data_i;
            fifo_pc[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    assign imem_req_valid_o = req_valid_q;
    assign imem_req_addr_o  = fetch_pc_q;
    assign inst_valid_o     = (state_q == ISSUE);
    assign first_cycle_o    = first_q;
    assign inst_o           = inst_q;
    assign opcode_o         = inst_q[6:0];
    assign funct3_o         = inst_q[14:12];
    assign funct7_o         = inst_q[31:25];
    assign pc_o             = pc_q;
    assign fetch_fault_o    = fault_q;

endmodule
